// File: rtl/fifo_wr_arb.sv
// Write-side arbiter for the async bridge FIFO: round-robin burst lock, full-gated write strobe.
// Define FIFO_WR_ARB_B2B_EN to drop the post-write gap cycle (only for FIFOs with a same-cycle exact full flag).
module fifo_wr_arb #(
   parameter int N_REQ     = 3,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4,
   localparam int ID_W     = $clog2(N_REQ),
   localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
   input  logic                      w_clk,
   input  logic                      w_rstn,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_last,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_w_inc,
   output logic [DATA_W-1:0]         fifo_w_data,
   output logic                      grant_vld,
   output logic [ID_W-1:0]           grant_id,
   output logic [CNT_W-1:0]          beat_cnt
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state_reg, state_next;
   logic [ID_W-1:0]   grant_id_reg, grant_id_next;
   logic [ID_W-1:0]   last_id_reg, last_id_next;
   logic [CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;
   logic              gap;
   logic              accept;
   logic              burst_end;
   logic [DATA_W-1:0] data_arr [N_REQ];

   // Lowest rotated offset from last_id+1 wins; the loop runs backwards so it is assigned last.
   function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [ID_W-1:0]  last);
      int idx;
      rr_pick = last;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = int'(last) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (valid[ID_W'(idx)]) rr_pick = ID_W'(idx);
      end
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
         assign req_ready[gi] = accept && (grant_id_reg == ID_W'(gi));
      end
   endgenerate

   assign accept    = (state_reg == BURST) && req_valid[grant_id_reg] && !fifo_full && !gap;
   assign burst_end = accept && (req_last[grant_id_reg] ||
                                 (beat_cnt_reg == CNT_W'(MAX_BURST - 1)));

   // The full flag lags a write by one cycle, so a quiet cycle follows every accepted beat.
`ifdef FIFO_WR_ARB_B2B_EN
   assign gap = 1'b0;
`else
   logic gap_reg;

   always_ff @(posedge w_clk or negedge w_rstn) begin
      if (!w_rstn) gap_reg <= 1'b0;
      else         gap_reg <= accept;
   end

   assign gap = gap_reg;
`endif

   always_ff @(posedge w_clk or negedge w_rstn) begin
      if (!w_rstn) begin
         state_reg    <= IDLE;
         grant_id_reg <= '0;
         last_id_reg  <= ID_W'(N_REQ - 1);
         beat_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         grant_id_reg <= grant_id_next;
         last_id_reg  <= last_id_next;
         beat_cnt_reg <= beat_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      grant_id_next = grant_id_reg;
      last_id_next  = last_id_reg;
      beat_cnt_next = beat_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (|req_valid) begin
               state_next    = BURST;
               grant_id_next = rr_pick(req_valid, last_id_reg);
               beat_cnt_next = '0;
            end
         end
         BURST: begin
            if (accept) beat_cnt_next = beat_cnt_reg + CNT_W'(1);
            if (burst_end) begin
               state_next   = IDLE;
               last_id_next = grant_id_reg;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      fifo_w_inc  = accept;
      fifo_w_data = accept ? data_arr[grant_id_reg] : '0;
      grant_vld   = (state_reg == BURST);
   end

   assign grant_id = grant_id_reg;
   assign beat_cnt = beat_cnt_reg;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: per-cycle vector table for a single burst plus scoreboarded multi-cycle sequences.
module tb_fifo_wr_arb;
   localparam int N  = 3;
   localparam int DW = 32;
   localparam int MB = 4;

   logic            w_clk = 1'b0;
   logic            w_rstn = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_last = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            fifo_full;
   logic            fifo_w_inc;
   logic [DW-1:0]   fifo_w_data;
   logic            grant_vld;
   logic [1:0]      grant_id;
   logic [2:0]      beat_cnt;

   logic full_tb = 1'b0;
   logic full_req = 1'b0;
   logic model_on = 1'b0;
   logic model_full;
   int   model_cnt;

   int total = 0;
   int bad = 0;
   int n_writes = 0;

   logic [N-1:0] en = '0;
   logic [N-1:0] use_last = '0;
   int seq [N];
   int nbeats [N];

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
   } sb_t;
   sb_t sbq [$];

   typedef struct {
      logic [2:0]  valid;
      logic [2:0]  last;
      logic        full;
      logic [31:0] data;
      logic        exp_inc;
      logic [2:0]  exp_ready;
      logic        exp_vld;
      logic [1:0]  exp_id;
      logic [2:0]  exp_cnt;
   } vec_t;
   vec_t vecs [8];
   int   n_vecs;

   always #5 w_clk = ~w_clk;

   assign fifo_full = model_on ? model_full : full_tb;

   // FIFO occupancy model whose full flag lags the write by an extra cycle.
   always @(posedge w_clk) begin
      if (!model_on) begin
         model_cnt  <= 0;
         model_full <= 1'b0;
      end else begin
         model_cnt  <= model_cnt + (fifo_w_inc ? 1 : 0);
         model_full <= (model_cnt >= 8);
      end
   end

   fifo_wr_arb #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .w_clk(w_clk), .w_rstn(w_rstn),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full),
      .fifo_w_inc(fifo_w_inc), .fifo_w_data(fifo_w_data),
      .grant_vld(grant_vld), .grant_id(grant_id), .beat_cnt(beat_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] v, input logic [2:0] l, input logic f,
                               input logic [31:0] d, input logic inc, input logic [2:0] rdy,
                               input logic vld, input logic [1:0] id, input logic [2:0] cnt);
      vec_t r;
      r.valid = v; r.last = l; r.full = f; r.data = d;
      r.exp_inc = inc; r.exp_ready = rdy; r.exp_vld = vld; r.exp_id = id; r.exp_cnt = cnt;
      return r;
   endfunction

   task automatic push_burst(input int id, input int from, input int upto);
      sb_t e;
      for (int s = from; s <= upto; s++) begin
         e.id   = 2'(id);
         e.data = {8'(id), 24'(s)};
         sbq.push_back(e);
      end
   endtask

   task automatic drive();
      @(negedge w_clk);
      full_tb = full_req;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = en[i] && (seq[i] < nbeats[i]);
         req_last[i]  = req_valid[i] && use_last[i] && (seq[i] == nbeats[i] - 1);
         req_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
      end
      #1;
   endtask

   task automatic monitor();
      sb_t e;
      if (fifo_full) chk("no_write_when_full", fifo_w_inc, 0);
      if (!fifo_w_inc) chk("wdata_zero_idle", fifo_w_data, 0);
      if (fifo_w_inc) begin
         n_writes++;
         $display("write id=%0d data=%h beat_cnt=%0d", grant_id, fifo_w_data, beat_cnt);
         if (model_on) chk("fifo_no_overflow", model_cnt < 8, 1);
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_write: got data %h expected no write", fifo_w_data);
         end else begin
            e = sbq.pop_front();
            chk("sb_data", fifo_w_data, e.data);
            chk("sb_grant_id", grant_id, e.id);
            chk("sb_ready", req_ready, 3'b001 << e.id);
         end
      end
      for (int i = 0; i < N; i++)
         if (req_valid[i] && req_ready[i]) seq[i]++;
   endtask

   task automatic run_cycle();
      drive();
      monitor();
   endtask

   task automatic run_until_seq(input string name, input int id, input int target);
      int cyc = 0;
      while (seq[id] < target && cyc < 300) begin
         run_cycle();
         cyc++;
      end
      chk(name, seq[id], target);
   endtask

   task automatic run_until_empty(input string name);
      int cyc = 0;
      while (sbq.size() != 0 && cyc < 300) begin
         run_cycle();
         cyc++;
      end
      chk(name, sbq.size(), 0);
   endtask

   task automatic apply_reset();
      en = '0; use_last = '0; full_req = 1'b0; full_tb = 1'b0; model_on = 1'b0;
      req_valid = '0; req_last = '0;
      for (int i = 0; i < N; i++) begin
         seq[i] = 0;
         nbeats[i] = 0;
      end
      sbq.delete();
      w_rstn = 1'b0;
      @(negedge w_clk);
      @(negedge w_clk);
      w_rstn = 1'b1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit found;

      // Reset state
      apply_reset();
      w_rstn = 1'b0;
      #1;
      chk("rst_grant_vld", grant_vld, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      chk("rst_w_inc", fifo_w_inc, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_wdata", fifo_w_data, 0);
      @(negedge w_clk);
      w_rstn = 1'b1;

      // Requester 0 three-beat burst, cycle by cycle
`ifdef FIFO_WR_ARB_B2B_EN
      vecs[0] = mk(3'b001, 3'b000, 0, 32'hA000_0000, 0, 3'b000, 0, 0, 0);
      vecs[1] = mk(3'b001, 3'b000, 0, 32'hA000_0000, 1, 3'b001, 1, 0, 0);
      vecs[2] = mk(3'b001, 3'b000, 0, 32'hA000_0001, 1, 3'b001, 1, 0, 1);
      vecs[3] = mk(3'b001, 3'b001, 0, 32'hA000_0002, 1, 3'b001, 1, 0, 2);
      vecs[4] = mk(3'b000, 3'b000, 0, 32'h0,         0, 3'b000, 0, 0, 3);
      vecs[5] = mk(3'b000, 3'b000, 0, 32'h0,         0, 3'b000, 0, 0, 3);
      n_vecs = 6;
`else
      vecs[0] = mk(3'b001, 3'b000, 0, 32'hA000_0000, 0, 3'b000, 0, 0, 0);
      vecs[1] = mk(3'b001, 3'b000, 0, 32'hA000_0000, 1, 3'b001, 1, 0, 0);
      vecs[2] = mk(3'b001, 3'b000, 0, 32'hA000_0001, 0, 3'b000, 1, 0, 1);
      vecs[3] = mk(3'b001, 3'b000, 0, 32'hA000_0001, 1, 3'b001, 1, 0, 1);
      vecs[4] = mk(3'b001, 3'b001, 0, 32'hA000_0002, 0, 3'b000, 1, 0, 2);
      vecs[5] = mk(3'b001, 3'b001, 0, 32'hA000_0002, 1, 3'b001, 1, 0, 2);
      vecs[6] = mk(3'b000, 3'b000, 0, 32'h0,         0, 3'b000, 0, 0, 3);
      vecs[7] = mk(3'b000, 3'b000, 0, 32'h0,         0, 3'b000, 0, 0, 3);
      n_vecs = 8;
`endif
      for (int r = 0; r < n_vecs; r++) begin
         @(negedge w_clk);
         req_valid = vecs[r].valid;
         req_last  = vecs[r].last;
         req_data  = {32'hBAD2_0002, 32'hBAD1_0001, vecs[r].data};
         full_tb   = vecs[r].full;
         #1;
         $display("vec %0d inc=%0d vld=%0d id=%0d cnt=%0d data=%h",
                  r, fifo_w_inc, grant_vld, grant_id, beat_cnt, fifo_w_data);
         chk("vec_w_inc", fifo_w_inc, vecs[r].exp_inc);
         chk("vec_ready", req_ready, vecs[r].exp_ready);
         chk("vec_grant_vld", grant_vld, vecs[r].exp_vld);
         chk("vec_grant_id", grant_id, vecs[r].exp_id);
         chk("vec_beat_cnt", beat_cnt, vecs[r].exp_cnt);
         chk("vec_wdata", fifo_w_data, vecs[r].exp_inc ? vecs[r].data : 32'h0);
      end

      // All requesters valid, no last: 4-beat truncated bursts in order 0,1,2,0
      apply_reset();
      en = 3'b111; use_last = 3'b000;
      nbeats[0] = 8; nbeats[1] = 4; nbeats[2] = 4;
      push_burst(0, 0, 3); push_burst(1, 0, 3); push_burst(2, 0, 3); push_burst(0, 4, 7);
      run_until_empty("rr_drained");
      repeat (3) run_cycle();
      chk("rr_idle_after", grant_vld, 0);
      chk("rr_last_cnt", beat_cnt, MB);

      // Full asserted for 5 cycles before beat 2
      apply_reset();
      en = 3'b001; use_last = 3'b001; nbeats[0] = 4;
      push_burst(0, 0, 3);
      run_until_seq("full_reach_beat2", 0, 1);
      full_req = 1'b1;
      repeat (5) begin
         run_cycle();
         chk("full_no_write", fifo_w_inc, 0);
         chk("full_no_ready", req_ready, 0);
         chk("full_lock_vld", grant_vld, 1);
         chk("full_lock_id", grant_id, 0);
      end
      full_req = 1'b0;
      run_cycle();
      chk("full_resume_first", fifo_w_inc, 1);
      run_until_empty("full_drained");
      repeat (2) run_cycle();

      // Granted requester drops valid 3 cycles while requester 1 waits
      apply_reset();
      en = 3'b011; use_last = 3'b011; nbeats[0] = 4; nbeats[1] = 2;
      push_burst(0, 0, 3); push_burst(1, 0, 1);
      run_until_seq("drop_reach", 0, 2);
      en = 3'b010;
      repeat (3) begin
         run_cycle();
         chk("drop_lock_id", grant_id, 0);
         chk("drop_lock_vld", grant_vld, 1);
         chk("drop_no_write", fifo_w_inc, 0);
      end
      en = 3'b011;
      run_until_empty("drop_drained");
      repeat (2) run_cycle();

      // Asynchronous reset during beat 2 of a requester-1 burst
      apply_reset();
      en = 3'b010; use_last = 3'b010; nbeats[1] = 4;
      push_burst(1, 0, 3);
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         drive();
         if (fifo_w_inc && seq[1] == 1) found = 1'b1;
         else monitor();
      end
      chk("arst_beat2_found", found, 1);
      w_rstn = 1'b0;
      #1;
      chk("arst_grant_vld", grant_vld, 0);
      chk("arst_grant_id", grant_id, 0);
      chk("arst_beat_cnt", beat_cnt, 0);
      chk("arst_w_inc", fifo_w_inc, 0);
      chk("arst_ready", req_ready, 0);
      chk("arst_wdata", fifo_w_data, 0);
      sbq.delete();
      en = 3'b000;
      drive();
      chk("arst_hold_no_write", fifo_w_inc, 0);
      drive();
      w_rstn = 1'b1;
      for (int i = 0; i < N; i++) seq[i] = 0;
      en = 3'b011; use_last = 3'b011; nbeats[0] = 2; nbeats[1] = 2;
      push_burst(0, 0, 1); push_burst(1, 0, 1);
      run_cycle();
      chk("arst_idle_after", grant_vld, 0);
      run_cycle();
      chk("arst_regrant_vld", grant_vld, 1);
      chk("arst_regrant_id", grant_id, 0);
      chk("arst_regrant_cnt", beat_cnt, 0);
      run_until_empty("arst_drained");
      repeat (2) run_cycle();

`ifndef FIFO_WR_ARB_B2B_EN
      // Fill an 8-entry FIFO with a lagging full flag
      apply_reset();
      model_on = 1'b1;
      en = 3'b001; use_last = 3'b000; nbeats[0] = 12;
      push_burst(0, 0, 7);
      n_writes = 0;
      repeat (80) run_cycle();
      chk("fill_write_count", n_writes, 8);
      chk("fill_drained", sbq.size(), 0);
      chk("fill_full_flag", fifo_full, 1);
      chk("fill_lock_held", grant_vld, 1);
      model_on = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Write-side arbiter and sequencer for the asynchronous bridge FIFO. Shares the single write port of the async FIFO write-pointer block among `N_REQ` requesters in the `w_clk` domain. Grants one requester at a time for a locked burst using round-robin order, gates every write with the FIFO full flag, and drives the FIFO write strobe and data. Sits between the AHB-side producers and the async FIFO write pointer/memory.

## Interface
- `N_REQ`, 3: number of requesters, 2..8.
- `DATA_W`, 32: FIFO data width.
- `MAX_BURST`, 4: maximum beats per grant, 1..16.
- `w_clk`  in  1: write-domain clock.
- `w_rstn`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: per-requester beat valid.
- `req_last`  in  N_REQ: per-requester last beat of burst; qualified by `req_valid`.
- `req_data`  in  N_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  N_REQ: beat accepted this cycle when `req_valid` and `req_ready` are both high.
- `fifo_full`  in  1: full flag from the FIFO write-pointer block.
- `fifo_w_inc`  out  1: FIFO write strobe; one beat is written per high cycle.
- `fifo_w_data`  out  DATA_W: data written with `fifo_w_inc`.
- `grant_vld`  out  1: a burst is locked; registered.
- `grant_id`  out  clog2(N_REQ): locked requester index; registered.
- `beat_cnt`  out  clog2(MAX_BURST+1): beats accepted in the current burst; registered.

## Operation
- FSM states:
  - IDLE: `grant_vld`=0, no writes.
  - BURST: `grant_vld`=1, writes allowed.
- IDLE, any `req_valid` high:
  - Round-robin pick starting at index (`last_id`+1) mod `N_REQ`.
  - Register `grant_id`, set `grant_vld`, clear `beat_cnt`, go to BURST.
- BURST, beat accepted when `req_valid[grant_id]` && !`fifo_full` && !`gap`:
  - `fifo_w_inc`=1, `req_ready[grant_id]`=1, `fifo_w_data`=`req_data[grant_id]`. These are combinational from registered state and inputs.
  - `beat_cnt` increments.
- BURST exit: an accepted beat with `req_last` high, or the accepted beat that makes `beat_cnt` equal `MAX_BURST`.
  - Next edge: go to IDLE, `last_id`<=`grant_id`, `grant_vld`<=0.
- `req_ready` is 0 for every non-granted requester and is always 0 in IDLE.
- `req_valid[grant_id]` low mid-burst: the lock holds and no write occurs. There is no timeout.
- `fifo_full` high mid-burst: the lock holds, `req_ready`=0 and `fifo_w_inc`=0. Resume on the first cycle `fifo_full` is low.
- `fifo_w_inc` is never high while `fifo_full` is high.
- Burst truncated at `MAX_BURST`: the remaining beats of that requester compete again in normal round-robin order.
- `gap` flag: set on each accepted beat, cleared the next cycle (see Configuration). It exists because the FIFO full flag lags an accepted write by one cycle.
- `fifo_w_data` = 0 when `fifo_w_inc` = 0.

## Timing
- Reset values: `grant_vld`=0, `grant_id`=0, `beat_cnt`=0, `fifo_w_inc`=0, `req_ready`=0, `fifo_w_data`=0, `gap`=0, state IDLE.
- `last_id` resets to `N_REQ`-1, so requester 0 wins the first arbitration.
- Request to first write: `req_valid` seen in IDLE at edge k → BURST after edge k → first `fifo_w_inc` in cycle k+1 if not full.
- One dead IDLE cycle always separates consecutive bursts.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronously). The partial burst is abandoned with no further writes.

## Configuration
- `FIFO_WR_ARB_B2B_EN` defined: `gap` is tied to 0 and back-to-back writes are allowed, 1 beat per cycle. Only for FIFOs whose full flag is exact in the same cycle.
- Not defined (default): after each accepted beat, the next cycle has `fifo_w_inc`=0. Peak rate is 1 beat per 2 cycles, which keeps the lagging full flag safe.

## Test plan
- Reset, then requester 0 sends a 3-beat burst (last on beat 3), FIFO never full: `grant_id`=0. Default build: writes in cycles 1, 3, 5, then IDLE. B2B build: writes in cycles 1, 2, 3.
- All three requesters valid continuously with no `req_last`, `MAX_BURST`=4: grants go 0,1,2,0 and each burst is exactly 4 writes.
- `fifo_full` forced high on beat 2 for 5 cycles: zero `fifo_w_inc`, `grant_id` unchanged, beat 2 written on the first cycle full is low, data order preserved.
- Granted requester drops `req_valid` for 3 cycles mid-burst while requester 1 is valid: the lock holds, no grant change, the burst completes afterwards.
- `w_rstn` pulsed low during beat 2 of a burst: outputs return to reset values immediately. After release, requester 0 regains priority and `beat_cnt` restarts at 0.
- Fill an 8-entry FIFO with no reads, default build: exactly 8 writes accepted and no overflow.
